serial_maskable_carry_adder: RTL and testbench
==============================================

Name: serial_maskable_carry_adder

Overview:
- Digit-serial, parametrised maskable-carry adder for the approximate multiplier datapath.
- Adds two WIDTH-bit operands one SLICE-bit slice per cycle, LSB slice first.
- A per-boundary carry mask can suppress the carry between adjacent slices, trading accuracy for a shorter carry chain.
- Uses valid/ready handshakes on both sides and flags whether any suppressed carry was actually non-zero.

Parameters:
WIDTH, 16, operand and sum width in bits.
SLICE, 4, bits added per cycle; WIDTH must be a multiple of SLICE.
NSLICE, WIDTH/SLICE, derived slice count; must be ≥2 (elaboration error otherwise).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operand set valid.
in_ready  out  1  block can accept operands.
a  in  WIDTH  operand A.
b  in  WIDTH  operand B.
cin  in  1  carry into slice 0.
carry_mask  in  NSLICE-1  bit i=1 suppresses the carry from slice i into slice i+1.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts result.
sum  out  WIDTH  result.
cout  out  1  carry out of the top slice (never masked).
carry_dropped  out  1  set if any masked boundary had carry=1.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=1.
  - out_valid=0, sum=0, cout=0, carry_dropped=0.
  - Slice index and internal carry cleared.
  - Any in-flight operation is discarded, with no partial output.
- FSM states IDLE, ADD, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready edge: register a, b, cin and carry_mask; idx=0; carry=cin; carry_dropped=0; go to ADD.
  - Port inputs are ignored after capture.
- ADD (in_ready=0):
  - Each cycle: {c,s} = a[idx] + b[idx] + carry, computed on SLICE+1 bits.
  - s is written to sum slice idx.
  - idx<NSLICE-1:
    - next carry = c & ~mask[idx].
    - carry_dropped |= c & mask[idx].
    - idx++.
  - idx=NSLICE-1: cout=c; go to DONE.
- DONE:
  - out_valid=1; sum, cout and carry_dropped held stable.
  - On out_valid&out_ready edge: out_valid=0; go to IDLE.
  - in_ready stays 0 in DONE, so there is no same-cycle re-accept.
- Latency:
  - Accept edge = edge 0; out_valid is high after edge NSLICE.
  - Minimum issue interval NSLICE+2 cycles, with out_ready held high.
- Outputs are registered.
- sum and cout keep their last value in IDLE.
- sum slices are visibly updated during ADD; consumers use them only when out_valid=1.
- carry_mask all-zero gives an exact result: sum = a+b+cin mod 2^WIDTH, and cout is the exact carry.
- Stalls of any length on out_ready are legal; no data loss.
- Reset mid-ADD or mid-DONE: immediate return to reset values; the next operation is unaffected.

Decomposition:
- Package serial_mca_pkg holds:
  - state enum (IDLE, ADD, DONE);
  - helper function for NSLICE and the index width, $clog2(NSLICE).
- One natural sub-module: slice_adder.
  - Combinational SLICE-bit ripple adder built from the team's half-adder/full-adder cells.
  - Inputs: a, b, ci. Outputs: s, co.
- Top level holds the FSM, operand registers, index counter, carry register and result registers.

Test Plan (WIDTH=16, SLICE=4):
1. a=0x00FF, b=0x0001, cin=0, mask=000 -> sum=0x0100, cout=0, carry_dropped=0; out_valid rises exactly 4 edges after accept.
2. Same operands with mask=001 -> sum=0x00F0, carry_dropped=1. With mask=010 -> sum=0x0000, carry_dropped=1.
3. a=0xFFFF, b=0x0001, mask=000 -> sum=0x0000, cout=1, carry_dropped=0. With mask=111 -> sum=0xFFF0, cout=0, carry_dropped=1.
4. a=0, b=0, cin=1, mask=111 -> sum=0x0001, cout=0, carry_dropped=0.
5. Backpressure: hold out_ready=0 for 6 cycles after out_valid, and toggle in_valid and the operand ports -> in_ready=0, and out_valid, sum and cout stay stable. On out_ready=1 -> IDLE next edge; the following op a=0x1234, b=0x1111 gives sum=0x2345.
6. Assert rst_n=0 asynchronously at idx=2 of an op -> out_valid=0 and in_ready=1 immediately. After release, a=0x0F0F, b=0x00F1, mask=000 -> sum=0x1000, cout=0.

Source files
------------

// File: rtl/serial_mca_pkg.sv
// Shared types and sizing helpers for the digit-serial maskable-carry adder.
package serial_mca_pkg;

    typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

    function automatic int unsigned nslice(int unsigned width, int unsigned slice);
        return width / slice;
    endfunction

    function automatic int unsigned idx_width(int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_maskable_carry_adder_if.sv
// Operand/result handshake bundle for serial_maskable_carry_adder.
interface serial_maskable_carry_adder_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
);
    localparam int unsigned NSlice = WIDTH / SLICE;

    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              cin;
    logic [NSlice-2:0] carry_mask;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  sum;
    logic              cout;
    logic              carry_dropped;

    modport master (
        output in_valid, a, b, cin, carry_mask, out_ready,
        input  in_ready, out_valid, sum, cout, carry_dropped
    );

    modport slave (
        input  in_valid, a, b, cin, carry_mask, out_ready,
        output in_ready, out_valid, sum, cout, carry_dropped
    );
endinterface

// File: rtl/serial_maskable_carry_adder_slice_adder.sv
// Combinational SLICE-bit ripple adder assembled from full-adder cells.
module slice_adder #(
    parameter int unsigned SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             co
);
    logic [SLICE:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < SLICE; i++) begin : gen_fa
        logic p;
        assign p      = a[i] ^ b[i];
        assign s[i]   = p ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (p & c[i]);
    end

    assign co = c[SLICE];
endmodule

// File: rtl/serial_maskable_carry_adder.sv
// Digit-serial adder: one SLICE-bit slice per cycle, LSB first, with per-boundary carry masking.
module serial_maskable_carry_adder
    import serial_mca_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input logic clk,
    input logic rst_n,
    serial_maskable_carry_adder_if.slave bus
);
    localparam int unsigned NSlice = nslice(WIDTH, SLICE);
    localparam int unsigned IdxW   = idx_width(NSlice);

    if (NSlice < 2 || (WIDTH % SLICE) != 0) begin : gen_param_err
        $error("serial_maskable_carry_adder: WIDTH must be a multiple of SLICE with >= 2 slices");
    end

    state_e            state_q;
    logic [WIDTH-1:0]  a_q, b_q, sum_q;
    logic [NSlice-2:0] mask_q;
    logic [IdxW-1:0]   idx_q;
    logic              carry_q, cout_q, dropped_q;
    logic              in_ready_q, out_valid_q;

    logic [SLICE-1:0]  s;
    logic              co;
    logic [NSlice-1:0] mask_ext;
    logic              mask_bit;
    logic              last;

    // Top boundary padded with 0 so the index never selects out of range.
    assign mask_ext = {1'b0, mask_q};
    assign mask_bit = mask_ext[idx_q];
    assign last     = (idx_q == IdxW'(NSlice - 1));

    slice_adder #(.SLICE(SLICE)) u_slice_adder (
        .a  (a_q[idx_q*SLICE +: SLICE]),
        .b  (b_q[idx_q*SLICE +: SLICE]),
        .ci (carry_q),
        .s  (s),
        .co (co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            mask_q      <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            dropped_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        mask_q     <= bus.carry_mask;
                        carry_q    <= bus.cin;
                        idx_q      <= '0;
                        dropped_q  <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= StAdd;
                    end
                end
                StAdd: begin
                    sum_q[idx_q*SLICE +: SLICE] <= s;
                    if (last) begin
                        cout_q      <= co;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        carry_q   <= co & ~mask_bit;
                        dropped_q <= dropped_q | (co & mask_bit);
                        idx_q     <= idx_q + 1'b1;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.sum           = sum_q;
    assign bus.cout          = cout_q;
    assign bus.carry_dropped = dropped_q;
endmodule

// File: tb/tb_serial_maskable_carry_adder.sv
// Self-checking bench for serial_maskable_carry_adder (WIDTH=16, SLICE=4).
module tb_serial_maskable_carry_adder;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned SLICE = 4;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        dropped;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [2:0]  mask;
        res_t        exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    serial_maskable_carry_adder_if #(.WIDTH(WIDTH), .SLICE(SLICE)) bus ();

    serial_maskable_carry_adder #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain slice-wise arithmetic on integers following the masking rules.
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic cin,
                                   input logic [2:0] mask);
        res_t r;
        int unsigned carry, t;
        r.sum = '0; r.cout = 1'b0; r.dropped = 1'b0;
        carry = cin;
        for (int i = 0; i < 4; i++) begin
            t = ((a >> (4 * i)) & 16'hF) + ((b >> (4 * i)) & 16'hF) + carry;
            r.sum = r.sum | 16'((t & 15) << (4 * i));
            carry = t >> 4;
            if (i < 3 && mask[i]) begin
                r.dropped = r.dropped | (carry != 0);
                carry = 0;
            end
        end
        r.cout = (carry != 0);
        return r;
    endfunction

    task automatic scramble_inputs();
        bus.a          = 16'($urandom);
        bus.b          = 16'($urandom);
        bus.cin        = 1'($urandom);
        bus.carry_mask = 3'($urandom);
    endtask

    // Issue one op, check latency/result, stall the consumer, then release.
    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic [2:0] mask, input res_t exp,
                         input int stall);
        int n;
        int lat;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid   = 1'b1;
        bus.a          = a;
        bus.b          = b;
        bus.cin        = cin;
        bus.carry_mask = mask;
        bus.out_ready  = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        scramble_inputs();
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (bus.out_valid !== 1'b1 && lat < 20);
        check({tag, " latency"}, 32'(lat), 32'd4);
        check({tag, " sum"}, 32'(bus.sum), 32'(exp.sum));
        check({tag, " cout"}, 32'(bus.cout), 32'(exp.cout));
        check({tag, " dropped"}, 32'(bus.carry_dropped), 32'(exp.dropped));
        for (int i = 0; i < stall; i++) begin
            bus.in_valid = 1'($urandom);
            scramble_inputs();
            @(posedge clk); #1;
            check({tag, " stall in_ready"}, 32'(bus.in_ready), 32'd0);
            check({tag, " stall out_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, " stall sum"}, 32'(bus.sum), 32'(exp.sum));
            check({tag, " stall cout"}, 32'(bus.cout), 32'(exp.cout));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, " release out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, " release in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        vec_t vecs[6];
        logic [15:0] ra, rb;
        logic        rc;
        logic [2:0]  rm;

        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 3'b000, '{16'h0100, 1'b0, 1'b0}};
        vecs[1] = '{16'h00FF, 16'h0001, 1'b0, 3'b001, '{16'h00F0, 1'b0, 1'b1}};
        vecs[2] = '{16'h00FF, 16'h0001, 1'b0, 3'b010, '{16'h0000, 1'b0, 1'b1}};
        vecs[3] = '{16'hFFFF, 16'h0001, 1'b0, 3'b000, '{16'h0000, 1'b1, 1'b0}};
        vecs[4] = '{16'hFFFF, 16'h0001, 1'b0, 3'b111, '{16'hFFF0, 1'b0, 1'b1}};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 3'b111, '{16'h0001, 1'b0, 1'b0}};

        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        scramble_inputs();
        #12;
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset sum", 32'(bus.sum), 32'd0);
        check("reset cout", 32'(bus.cout), 32'd0);
        check("reset dropped", 32'(bus.carry_dropped), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i])
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].mask,
                  vecs[i].exp, 0);

        // Backpressure for 6 cycles, then a follow-up op.
        do_op("bp", 16'h00FF, 16'h0001, 1'b0, 3'b000, '{16'h0100, 1'b0, 1'b0}, 6);
        do_op("bp next", 16'h1234, 16'h1111, 1'b0, 3'b000, '{16'h2345, 1'b0, 1'b0}, 0);

        // Asynchronous reset while idx=2.
        bus.in_valid   = 1'b1;
        bus.a          = 16'hFFFF;
        bus.b          = 16'hFFFF;
        bus.cin        = 1'b1;
        bus.carry_mask = 3'b000;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("midreset out_valid", 32'(bus.out_valid), 32'd0);
        check("midreset in_ready", 32'(bus.in_ready), 32'd1);
        check("midreset sum", 32'(bus.sum), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op("post reset", 16'h0F0F, 16'h00F1, 1'b0, 3'b000, '{16'h1000, 1'b0, 1'b0}, 0);

        for (int k = 0; k < 40; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            rm = (k % 4 == 0) ? 3'b000 : 3'($urandom);
            do_op($sformatf("rand%0d", k), ra, rb, rc, rm, model(ra, rb, rc, rm),
                  int'($urandom_range(0, 3)));
            if (rm == 3'b000)
                check($sformatf("rand%0d exact", k), 32'(bus.sum),
                      32'(16'(32'(ra) + 32'(rb) + 32'(rc))));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
